// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller loader, redirect and instruction-memory signal bundle
// master is the controller side; slave is the loader/CPU/memory side.
interface fetch_ctrl_if;
  logic        start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        ld_req;
  logic        ld_ready;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        jump_r;
  logic [31:0] pc_branch;
  logic [31:0] imm;
  logic [31:0] rs1value;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] curr_addr;
  logic [31:0] next_addr;
  logic        fetch_valid;
  logic        flush_ifid;
  logic        ld_overflow;
  logic [1:0]  state_o;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
  logic [31:0] misalign_addr;

  modport master (
    input  start, ld_valid, ld_data, ld_done, ld_req, stall, branch_taken, jump, jump_r,
           pc_branch, imm, rs1value,
    output ld_ready, imem_addr, imem_we, imem_wdata, curr_addr, next_addr, fetch_valid,
           flush_ifid, ld_overflow, state_o, misalign_err, misalign_addr
  );
  modport slave (
    output start, ld_valid, ld_data, ld_done, ld_req, stall, branch_taken, jump, jump_r,
           pc_branch, imm, rs1value,
    input  ld_ready, imem_addr, imem_we, imem_wdata, curr_addr, next_addr, fetch_valid,
           flush_ifid, ld_overflow, state_o, misalign_err, misalign_addr
  );
`else
  modport master (
    input  start, ld_valid, ld_data, ld_done, ld_req, stall, branch_taken, jump, jump_r,
           pc_branch, imm, rs1value,
    output ld_ready, imem_addr, imem_we, imem_wdata, curr_addr, next_addr, fetch_valid,
           flush_ifid, ld_overflow, state_o
  );
  modport slave (
    output start, ld_valid, ld_data, ld_done, ld_req, stall, branch_taken, jump, jump_r,
           pc_branch, imm, rs1value,
    input  ld_ready, imem_addr, imem_we, imem_wdata, curr_addr, next_addr, fetch_valid,
           flush_ifid, ld_overflow, state_o
  );
`endif
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer sharing IMEM between loader and CPU fetch
// Optional macro FETCH_ALIGN_CHECK_EN: suppress misaligned redirects and report them.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] LOAD_BASE  = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input logic        clk,
  input logic        rst,
  fetch_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(IMEM_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IMEM_WORDS);

  localparam logic [1:0] S_BOOT  = 2'b00;
  localparam logic [1:0] S_LOAD  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_DRAIN = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             flush_q, flush_d;
  logic [31:0]      target;
  logic [31:0]      ld_ptr;
  logic             redirect_req;
  logic             redirect;
  logic             accept;

  assign target       = bus.jump_r ? ((bus.rs1value + bus.imm) & 32'hFFFF_FFFE)
                                   : (bus.pc_branch + bus.imm);
  assign redirect_req = bus.jump_r | bus.jump | bus.branch_taken;
  assign accept       = (state_q == S_LOAD) && bus.ld_valid;
  // Word index wraps naturally at IMEM_WORDS; the byte offset is rebuilt from it.
  assign ld_ptr       = LOAD_BASE + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic        mis_err_q, mis_err_d;
  logic [31:0] mis_addr_q, mis_addr_d;
  logic        misaligned;

  assign misaligned = (target[1:0] != 2'b00);
  assign redirect   = redirect_req && !misaligned;

  always_comb begin
    mis_err_d  = mis_err_q;
    mis_addr_d = mis_addr_q;
    if (state_q == S_RUN && redirect_req && misaligned) begin
      mis_err_d  = 1'b1;
      mis_addr_d = target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_err_q  <= 1'b0;
      mis_addr_q <= 32'h0;
    end else begin
      mis_err_q  <= mis_err_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign bus.misalign_err  = mis_err_q;
  assign bus.misalign_addr = mis_addr_q;
`else
  assign redirect = redirect_req;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    flush_d = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (bus.ld_valid) begin
          state_d = S_LOAD;
          idx_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (bus.start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
      S_LOAD: begin
        if (accept) begin
          idx_d = idx_q + 1'b1;
          if (cnt_q == CNT_FULL) ovf_d = 1'b1;
          else                   cnt_d = cnt_q + 1'b1;
        end
        // A word offered together with ld_done is written before leaving.
        if (bus.ld_done) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        flush_d = redirect;
        if (redirect)       pc_d = target;
        else if (!bus.stall) pc_d = pc_q + 32'd4;
        if (bus.ld_req && !redirect) state_d = S_DRAIN;
      end
      default: begin
        state_d = S_LOAD;
        idx_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      flush_q <= flush_d;
    end
  end

  assign bus.ld_ready    = (state_q == S_LOAD);
  assign bus.imem_we     = accept;
  assign bus.imem_addr   = (state_q == S_LOAD) ? ld_ptr : pc_q;
  assign bus.imem_wdata  = accept ? bus.ld_data : 32'h0;
  assign bus.curr_addr   = pc_q;
  assign bus.next_addr   = pc_q + 32'd4;
  assign bus.fetch_valid = (state_q == S_RUN) && !flush_q;
  assign bus.flush_ifid  = flush_q || (state_q == S_DRAIN);
  assign bus.ld_overflow = ovf_q;
  assign bus.state_o     = state_q;
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch datapath.
- Owns the single-port instruction memory and shares it between the program loader (boot and reload) and the CPU fetch path.
- Computes the next PC using the priority jalr > jal > branch > sequential.
- Generates the IF/ID flush and fetch-valid qualifiers consumed by the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on entering RUN.
- LOAD_BASE, 32'h0000_0000, first loader write address.
- IMEM_WORDS, 256, instruction memory depth in 32-bit words (power of 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leave BOOT without loading.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_done  in  1  loader finished (sampled in LOAD).
- ld_req  in  1  request a reload while in RUN.
- ld_ready  out  1  controller accepts a loader word this cycle.
- stall  in  1  hold the PC (hazard from ID/EX).
- branch_taken  in  1  conditional branch resolved taken.
- jump  in  1  JAL.
- jump_r  in  1  JALR.
- pc_branch  in  32  base PC for branch/JAL.
- imm  in  32  offset.
- rs1value  in  32  JALR base.
- imem_addr  out  32  byte address to instruction memory.
- imem_we  out  1  instruction memory write enable.
- imem_wdata  out  32  instruction memory write data.
- curr_addr  out  32  PC of the instruction currently fetched.
- next_addr  out  32  curr_addr + 4.
- fetch_valid  out  1  instruction memory data is a real fetch.
- flush_ifid  out  1  kill the instruction in IF/ID.
- ld_overflow  out  1  sticky: loader exceeded IMEM_WORDS.
- state_o  out  2  00 BOOT, 01 LOAD, 10 RUN, 11 DRAIN.

Behaviour:
Reset (async, rst=1):
- state=BOOT, curr_addr=RESET_PC, load pointer=LOAD_BASE, load count=0.
- All 1-bit outputs 0; imem_addr=RESET_PC; imem_wdata=0.

BOOT:
- ld_valid=1 → LOAD. Otherwise start=1 → RUN with curr_addr=RESET_PC.
- ld_valid has priority over start.

LOAD:
- ld_ready=1.
- On ld_valid: imem_we=1 (combinational), imem_addr=load pointer, imem_wdata=ld_data; pointer += 4 and count += 1 next cycle.
- Pointer wraps modulo IMEM_WORDS*4 relative to LOAD_BASE.
- A word accepted when count==IMEM_WORDS sets ld_overflow; the write still occurs (wraps).
- ld_done=1 → RUN, curr_addr=RESET_PC, pointer reset to LOAD_BASE. A simultaneous ld_valid word is written first.

RUN:
- imem_addr=curr_addr; fetch_valid=1 except in the cycle following a redirect; imem_we=0.
- Next-PC priority:
  - jump_r: (rs1value+imm) & ~1
  - jump: pc_branch+imm
  - branch_taken: pc_branch+imm
  - stall: hold
  - else: curr_addr+4
- A redirect overrides stall.
- A redirect asserts flush_ifid for exactly 1 cycle (the same cycle the redirect is sampled, registered at the next edge).
- All arithmetic is 32-bit modulo 2^32 with no overflow flag.
- ld_req=1 → DRAIN, unless a redirect is sampled in the same cycle; then the redirect completes first and DRAIN is entered on the next cycle if ld_req is still high.

DRAIN:
- 1 cycle: fetch_valid=0, flush_ifid=1, then → LOAD.
- ld_overflow is cleared on entering LOAD.

Other rules:
- ld_ready=0 outside LOAD.
- Loader words offered outside LOAD are ignored, except that in BOOT ld_valid triggers LOAD and that first word is accepted one cycle later (held by the loader).

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect target with bits[1:0] != 0 is suppressed: PC advances as if no redirect, and no flush is issued.
  - Sets output misalign_err (1 bit, sticky until reset) and latches the target into output misalign_addr (32).
- Undefined:
  - Those ports are absent.
  - Targets are used unchecked; bit 1 is passed through.

Test Plan:
- Reset, then start=1 → RUN; curr_addr sequence 0, 4, 8, 12; fetch_valid=1; flush_ifid=0.
- BOOT load 0x11111111, 0x22222222, 0x33333333 then ld_done → writes to addresses 0, 4, 8 with imem_we pulses; then RUN from 0x0.
- RUN at curr_addr=0x8 with branch_taken=1, pc_branch=0x8, imm=16 → next curr_addr=0x18; flush_ifid=1 for one cycle; fetch_valid=0 for one cycle.
- jump_r=1 and jump=1 together with rs1value=100, imm=5 → next PC=0x68 (JALR wins, LSB cleared).
- stall=1 for 3 cycles at 0x10 → PC held at 0x10. Then stall=1 with jump=1, pc_branch=0x10, imm=32 → PC=0x30.
- IMEM_WORDS=4: load 5 words → ld_overflow=1 and the fifth write goes to 0x0. Assert rst mid-load → immediately state=BOOT and all outputs at reset values.
